// File: rtl/mcu_subsys_pkg.sv
// Shared definitions for the MCU subsystem peripheral UART: register offsets,
// register bit indices and the transmitter state encoding.
package mcu_subsys_pkg;

  // Word offsets, i.e. addr[4:2]
  localparam logic [2:0] UART_TXDATA_OFS   = 3'd0;
  localparam logic [2:0] UART_STATUS_OFS   = 3'd1;
  localparam logic [2:0] UART_BAUD_DIV_OFS = 3'd2;
  localparam logic [2:0] UART_CTRL_OFS     = 3'd3;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_EMPTY     = 2;
  localparam int STATUS_OVF       = 3;
  localparam int STATUS_LEVEL_LSB = 4;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PAR_ODD = 2;

  localparam logic [15:0] BAUD_DIV_MIN = 16'd2;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_tx_state_e;

  function automatic logic [15:0] clamp_baud(input logic [15:0] value);
    return (value < BAUD_DIV_MIN) ? BAUD_DIV_MIN : value;
  endfunction

endpackage

// File: rtl/mcu_subsys_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module mcu_subsys_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];
  assign level = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcu_subsys_periph_uart.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, baud divider and TX-done irq.
// Define MCU_UART_PARITY_EN to insert a parity bit (CTRL.PAR_ODD selects odd).
//
//  state  | meaning
//  IDLE   | line high, waiting for TX_EN and a queued byte
//  START  | start bit (0)
//  DATA   | 8 data bits, LSB first
//  PARITY | parity bit (parity builds only)
//  STOP   | stop bit (1); may chain straight into the next START
module mcu_subsys_periph_uart
  import mcu_subsys_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        periph_mem_valid,
  output logic        periph_mem_ready,
  input  logic [31:0] periph_mem_addr,
  input  logic [31:0] periph_mem_wdata,
  input  logic [3:0]  periph_mem_wstrb,
  output logic [31:0] periph_mem_rdata,
  output logic        uart_tx,
  output logic        uart_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e state;
  logic [15:0]    baud_div;
  logic [15:0]    baud_cnt;
  logic [2:0]     ctrl;
  logic           ovf;
  logic [7:0]     shift;
  logic [2:0]     bit_idx;
  logic           req, wr, push, pop, bit_end, busy;
  logic [2:0]     sel;
  logic [7:0]     fifo_dout;
  logic           fifo_full, fifo_empty;
  logic [LW-1:0]  fifo_level;
  logic [31:0]    status_word, rd_word;
  logic [15:0]    baud_next;
  logic           unused_ok;
`ifdef MCU_UART_PARITY_EN
  logic           parity;
`endif

  assign unused_ok = ^{periph_mem_addr[31:5], periph_mem_addr[1:0],
                       periph_mem_wdata[31:16], periph_mem_wstrb[3:2]};

  assign req     = periph_mem_valid & ~periph_mem_ready;
  assign wr      = |periph_mem_wstrb;
  assign sel     = periph_mem_addr[4:2];
  assign push    = req & wr & (sel == UART_TXDATA_OFS) & periph_mem_wstrb[0];
  assign busy    = (state != UART_IDLE);
  assign bit_end = (baud_cnt <= 16'd1);
  assign pop     = ctrl[CTRL_TX_EN] & ~fifo_empty &
                   ((state == UART_IDLE) | ((state == UART_STOP) & bit_end));
  assign uart_irq = ctrl[CTRL_IRQ_EN] & fifo_empty & ~busy;

  assign baud_next = {periph_mem_wstrb[1] ? periph_mem_wdata[15:8] : baud_div[15:8],
                      periph_mem_wstrb[0] ? periph_mem_wdata[7:0]  : baud_div[7:0]};

  mcu_subsys_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (periph_mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY]  = busy;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_OVF]   = ovf;
    status_word[STATUS_LEVEL_LSB +: LW] = fifo_level;
    case (sel)
      UART_STATUS_OFS:   rd_word = status_word;
      UART_BAUD_DIV_OFS: rd_word = {16'd0, baud_div};
      UART_CTRL_OFS:     rd_word = {29'd0, ctrl};
      default:           rd_word = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      periph_mem_ready <= 1'b0;
      periph_mem_rdata <= '0;
      baud_div         <= BAUD_DIV_RST;
      ctrl             <= '0;
      ovf              <= 1'b0;
    end else begin
      periph_mem_ready <= req;
      periph_mem_rdata <= req ? rd_word : '0;
      if (req && wr) begin
        case (sel)
          UART_STATUS_OFS:
            if (periph_mem_wstrb[0] && periph_mem_wdata[STATUS_OVF]) ovf <= 1'b0;
          UART_BAUD_DIV_OFS: baud_div <= clamp_baud(baud_next);
          UART_CTRL_OFS:
            if (periph_mem_wstrb[0]) begin
              ctrl[CTRL_TX_EN]  <= periph_mem_wdata[CTRL_TX_EN];
              ctrl[CTRL_IRQ_EN] <= periph_mem_wdata[CTRL_IRQ_EN];
`ifdef MCU_UART_PARITY_EN
              ctrl[CTRL_PAR_ODD] <= periph_mem_wdata[CTRL_PAR_ODD];
`else
              ctrl[CTRL_PAR_ODD] <= 1'b0;
`endif
            end
          default: ;
        endcase
      end
      // full implies non-empty, so pop here means the pushed byte was taken
      if (push && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
`ifdef MCU_UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      if (state != UART_IDLE) baud_cnt <= bit_end ? baud_div : baud_cnt - 16'd1;
      if (pop) begin
        state    <= UART_START;
        uart_tx  <= 1'b0;
        shift    <= fifo_dout;
        baud_cnt <= baud_div;
`ifdef MCU_UART_PARITY_EN
        parity   <= ^fifo_dout ^ ctrl[CTRL_PAR_ODD];
`endif
      end else if (bit_end) begin
        case (state)
          UART_START: begin
            state   <= UART_DATA;
            uart_tx <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
          UART_DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef MCU_UART_PARITY_EN
              state   <= UART_PARITY;
              uart_tx <= parity;
`else
              state   <= UART_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[0];
              shift   <= shift >> 1;
            end
          end
          UART_PARITY: begin
            state   <= UART_STOP;
            uart_tx <= 1'b1;
          end
          UART_STOP: begin
            state   <= UART_IDLE;
            uart_tx <= 1'b1;
          end
          default: begin
            state   <= UART_IDLE;
            uart_tx <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_subsys_periph_uart.sv
// Directed bench for mcu_subsys_periph_uart; parity checks run when
// MCU_UART_PARITY_EN is defined.
module tb_mcu_subsys_periph_uart;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int vectors = 0;
  int errors  = 0;

  mcu_subsys_periph_uart #(.FIFO_DEPTH(16), .BAUD_DIV_RST(16'd434)) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .periph_mem_valid (valid),
    .periph_mem_ready (ready),
    .periph_mem_addr  (addr),
    .periph_mem_wdata (wdata),
    .periph_mem_wstrb (wstrb),
    .periph_mem_rdata (rdata),
    .uart_tx          (tx),
    .uart_irq         (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    bit got = 0;
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    r = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge sys_clk);
      if (ready) begin got = 1; r = rdata; end
    end
    valid = 1'b0; wstrb = '0;
    if (!got) begin
      vectors++; errors++;
      $display("FAIL bus_timeout addr=%h: ready never seen", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(a, d, s, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bus(a, 32'd0, 4'd0, r);
  endtask

  task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    rd(a, r);
    vectors++;
    if (r !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, r, exp);
    end
  endtask

  task automatic wait_start(input string name, output bit found);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge sys_clk);
      if (tx === 1'b0) found = 1;
    end
    if (!found) begin
      vectors++; errors++;
      $display("FAIL %s_start: no start bit within 300 cycles", name);
    end
  endtask

  // Called on the first negedge of the start bit; checks every cycle of the frame.
  task automatic check_frame(input string name, input logic [31:0] bits,
                             input int nbits, input int div);
    for (int b = 0; b < nbits; b++) begin
      int bad = 0;
      for (int c = 0; c < div; c++) begin
        if (b != 0 || c != 0) @(negedge sys_clk);
        if (tx !== bits[b]) bad++;
      end
      vectors++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: got %b on %0d cycles, expected %b", name, b, tx, bad, bits[b]);
      end
    end
    @(negedge sys_clk);
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: got %b expected 1", name, tx);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    vectors++;
    if ({ready, rdata, tx, irq} !== {1'b0, 32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h tx=%b irq=%b expected 0,0,1,0",
               ready, rdata, tx, irq);
    end
    expect_reg("reset_status", 32'h04, 32'h0000_0004);
    expect_reg("reset_baud", 32'h08, 32'h0000_01B2);
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx_idle: got %b expected 1", tx);
    end
  endtask

  task automatic test_single_frame();
    bit found;
    wr(32'h08, 32'd4, 4'hF);
    wr(32'h0C, 32'd1, 4'hF);
    wr(32'h00, 32'h55, 4'h1);
    wait_start("frame55", found);
    if (found) check_frame("frame55", {22'd0, 1'b1, 8'h55, 1'b0}, 10, 4);
    expect_reg("frame55_status", 32'h04, 32'h0000_0004);
    wr(32'h0C, 32'd3, 4'h1);
    vectors++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_on: got %b expected 1", irq); end
    wr(32'h0C, 32'd1, 4'h1);
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_off: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    bit found;
    wr(32'h0C, 32'd0, 4'h1);
    wr(32'h00, 32'hA5, 4'h1);
    wr(32'h00, 32'h3C, 4'h1);
    expect_reg("b2b_queued", 32'h04, 32'h0000_0020);
    wr(32'h0C, 32'd1, 4'h1);
    wait_start("b2b", found);
    if (found) check_frame("b2b", {12'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, 4);
    expect_reg("b2b_status", 32'h04, 32'h0000_0004);
  endtask

  task automatic test_overflow();
    wr(32'h0C, 32'd0, 4'h1);
    for (int i = 0; i < 17; i++) wr(32'h00, i, 4'h1);
    expect_reg("ovf_status", 32'h04, 32'h0000_010A);
    wr(32'h04, 32'h8, 4'h1);
    expect_reg("ovf_clear", 32'h04, 32'h0000_0102);
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    wr(32'h0C, 32'd1, 4'h1);
    wait_start("midrst", found);
    repeat (8) @(negedge sys_clk);
    vectors++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midrst_data0: got %b expected 0", tx); end
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    vectors++;
    if (tx !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got tx=%b ready=%b expected 1,0", tx, ready);
    end
    expect_reg("midrst_status", 32'h04, 32'h0000_0004);
    expect_reg("midrst_baud", 32'h08, 32'h0000_01B2);
    expect_reg("midrst_ctrl", 32'h0C, 32'h0000_0000);
    repeat (5) @(negedge sys_clk);
    vectors++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_quiet: got %b expected 1", tx); end
  endtask

  task automatic test_unmapped();
    valid = 1'b1; addr = 32'h1C; wstrb = 4'h0;
    @(negedge sys_clk);
    vectors++;
    if (ready !== 1'b1 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read: got ready=%b rdata=%h expected 1,0", ready, rdata);
    end
    @(negedge sys_clk);
    vectors++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse_width: got ready=%b expected 0", ready);
    end
    valid = 1'b0;
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    expect_reg("unmapped_reread", 32'h1C, 32'h0);
    expect_reg("unmapped_baud", 32'h08, 32'h0000_01B2);
    expect_reg("unmapped_ctrl", 32'h0C, 32'h0);
  endtask

  task automatic test_baud_reg();
    wr(32'h08, 32'h0000_0001, 4'h3);
    expect_reg("baud_clamp", 32'h08, 32'h0000_0002);
    wr(32'h08, 32'h0000_1234, 4'h2);
    expect_reg("baud_bytestrobe", 32'h08, 32'h0000_1202);
    wr(32'h08, 32'h0000_0002, 4'h3);
  endtask

  task automatic test_parity();
    bit found;
`ifdef MCU_UART_PARITY_EN
    wr(32'h0C, 32'd5, 4'h1);
    expect_reg("ctrl_par_rw", 32'h0C, 32'h0000_0005);
    wr(32'h0C, 32'd0, 4'h1);
    wr(32'h00, 32'h07, 4'h1);
    wr(32'h0C, 32'd1, 4'h1);
    wait_start("parity", found);
    if (found) check_frame("parity", {21'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2);
`else
    wr(32'h0C, 32'd6, 4'h1);
    expect_reg("ctrl_par_ro", 32'h0C, 32'h0000_0002);
    wr(32'h0C, 32'd0, 4'h1);
    wr(32'h00, 32'h07, 4'h1);
    wr(32'h0C, 32'd1, 4'h1);
    wait_start("noparity", found);
    if (found) check_frame("noparity", {22'd0, 1'b1, 8'h07, 1'b0}, 10, 2);
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_unmapped();
    test_baud_reg();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
